data_mem_arbiter: RTL
=====================

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 Parameter MEM_DEPTH, default 256, is the number of valid data-memory words; addresses >= MEM_DEPTH are out of range.
REQ-002 CLK  input  1  single clock; all state changes on the rising edge.
REQ-003 RESET_N  input  1  reset; asynchronous, active-low.
REQ-004 A_REQ  input  1  port A (CPU) access request.
REQ-005 A_WE  input  1  port A: 1 = write, 0 = read.
REQ-006 A_ADDR  input  10  port A word address.
REQ-007 A_WDATA  input  10  port A write data.
REQ-008 A_GNT  output  1  port A request accepted; one-cycle pulse.
REQ-009 A_DONE  output  1  port A access complete; one-cycle pulse.
REQ-010 A_ERR  output  1  qualifies A_DONE; 1 = address out of range.
REQ-011 A_RDATA  output  10  port A read data; valid while A_DONE=1 on a read.
REQ-012 B_REQ, B_WE, B_ADDR, B_WDATA, B_GNT, B_DONE, B_ERR, B_RDATA: port B (DMA/debug), same directions, widths and meanings as port A.
REQ-013 MEM_WRITE  output  1  write enable to the data memory.
REQ-014 MEM_ADDRESS  output  10  address to the data memory.
REQ-015 MEM_WDATA  output  10  write data to the data memory.
REQ-016 MEM_RDATA  input  10  read data from the data memory; registered, valid the cycle after the sampling edge.
REQ-017 BUSY  output  1  1 whenever the FSM is not in IDLE.

Function
REQ-018 The FSM SHALL have three states: IDLE -> ACCESS -> RESP -> IDLE. It leaves IDLE only when A_REQ or B_REQ is high at a rising edge.
REQ-019 On the IDLE->ACCESS edge, the block SHALL capture the winner's WE/ADDR/WDATA and drive them on MEM_* during ACCESS. The winner's GNT SHALL be 1 for that ACCESS cycle only.
REQ-020 MEM_WRITE SHALL be 1 only in ACCESS, only for an in-range write, and for exactly one cycle; otherwise 0.
REQ-021 During RESP, MEM_RDATA SHALL be sampled. On the RESP->IDLE edge, the owner's DONE SHALL pulse for one cycle, with RDATA = MEM_RDATA for a read and 0 for a write.
REQ-022 Latency: REQ sampled at edge n gives GNT in cycle n+1 and DONE in cycle n+3; throughput is one access per 3 cycles.
REQ-023 Requesters SHALL hold REQ/WE/ADDR/WDATA stable until GNT. Inputs after the grant edge SHALL NOT affect the in-flight access.
REQ-024 REQ still high in IDLE after DONE SHALL be treated as a new request.
REQ-025 Out-of-range address: MEM_WRITE stays 0, the FSM still passes through ACCESS and RESP, then DONE=1, ERR=1, RDATA=0.
REQ-026 REQ changes while BUSY=1 SHALL be ignored until the FSM returns to IDLE; there is no queueing.
REQ-027 Only one GNT and one DONE SHALL be high in any cycle. RDATA/ERR SHALL hold their value between DONE pulses.

Reset
REQ-028 RESET_N=0 SHALL immediately force IDLE, clear the round-robin pointer to "A next", and drive all outputs to 0. An in-flight access SHALL be abandoned, with no DONE and no write performed.
REQ-029 After RESET_N rises, the first edge with a request SHALL grant normally.

Configuration
REQ-030 With ARB_ROUND_ROBIN_EN defined, simultaneous requests SHALL be granted to the port that did not win the previous grant (A first after reset). A lone requester always wins.
REQ-031 Without ARB_ROUND_ROBIN_EN, port A SHALL always win simultaneous requests and the pointer logic SHALL be absent.

Verification
REQ-032 A writes 0x155 to addr 0x012, then reads 0x012 -> A_GNT at n+1, MEM_WRITE pulses once, A_DONE at n+3, read A_RDATA=0x155, A_ERR=0.
REQ-033 A_REQ and B_REQ held high for 4 grants with ARB_ROUND_ROBIN_EN -> grant order A,B,A,B; without the macro -> A,A,A,A.
REQ-034 B writes addr 0x100 with MEM_DEPTH=256 -> MEM_WRITE stays 0, B_DONE=1, B_ERR=1, B_RDATA=0.
REQ-035 RESET_N pulsed low during ACCESS of an A write -> MEM_WRITE drops at once, no A_DONE, BUSY=0, memory word unchanged.
REQ-036 B_REQ raised during A's ACCESS -> no B_GNT until IDLE; B_GNT in the cycle after A_DONE's IDLE edge, B_DONE 2 cycles later.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - two-port arbiter in front of a single-ported registered data memory
//
// Purpose: grants one of two requesters (A = CPU, B = DMA/debug) access to the
// data memory. Each access takes three cycles: IDLE -> ACCESS -> RESP -> IDLE.
// Out-of-range addresses (>= MEM_DEPTH) still take the full three cycles. They
// never write memory, and they complete with ERR=1 and RDATA=0.
//
// Optional feature: define ARB_ROUND_ROBIN_EN to alternate the winner of
// simultaneous requests. When it is undefined, port A always wins a tie.
//
// Ports:
//   CLK, RESET_N               clock, asynchronous active-low reset
//   A_REQ/A_WE/A_ADDR/A_WDATA  port A request, held by the requester until A_GNT
//   A_GNT                      port A accepted (ACCESS cycle only)
//   A_DONE/A_ERR/A_RDATA       port A completion pulse, error flag, read data
//   B_*                        port B, same meaning as port A
//   MEM_WRITE/MEM_ADDRESS/MEM_WDATA  memory command, driven during ACCESS
//   MEM_RDATA                  registered memory read data (valid during RESP)
//   BUSY                       high whenever an access is in flight
module data_mem_arbiter #(
  parameter int MEM_DEPTH = 256
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       A_REQ,
  input  logic       A_WE,
  input  logic [9:0] A_ADDR,
  input  logic [9:0] A_WDATA,
  output logic       A_GNT,
  output logic       A_DONE,
  output logic       A_ERR,
  output logic [9:0] A_RDATA,
  input  logic       B_REQ,
  input  logic       B_WE,
  input  logic [9:0] B_ADDR,
  input  logic [9:0] B_WDATA,
  output logic       B_GNT,
  output logic       B_DONE,
  output logic       B_ERR,
  output logic [9:0] B_RDATA,
  output logic       MEM_WRITE,
  output logic [9:0] MEM_ADDRESS,
  output logic [9:0] MEM_WDATA,
  input  logic [9:0] MEM_RDATA,
  output logic       BUSY
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t      state_q;
  state_t      state_d;

  logic        owner_b_q;
  logic        we_q;
  logic [9:0]  addr_q;
  logic [9:0]  wdata_q;

  logic        start;
  logic        win_b;
  logic        in_range;
  logic [31:0] addr_ext;
  logic [9:0]  resp_data;

  logic        a_done_q;
  logic        a_err_q;
  logic [9:0]  a_rdata_q;
  logic        b_done_q;
  logic        b_err_q;
  logic [9:0]  b_rdata_q;

  // A new access may only begin from IDLE. Request changes while busy are ignored.
  assign start = (state_q == IDLE) && (A_REQ || B_REQ);

`ifdef ARB_ROUND_ROBIN_EN
  // b_first_q = 1 means port B wins the next tie. Reset gives A the first tie.
  logic b_first_q;

  assign win_b = B_REQ && (!A_REQ || b_first_q);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      b_first_q <= 1'b0;
    end else if (start) begin
      b_first_q <= !win_b;
    end
  end
`else
  assign win_b = B_REQ && !A_REQ;
`endif

  // The captured address stays constant from the grant until the next IDLE,
  // so a single range check serves both the write gate and the response.
  assign addr_ext  = {22'd0, addr_q};
  assign in_range  = addr_ext < 32'(MEM_DEPTH);
  assign resp_data = (in_range && !we_q) ? MEM_RDATA : 10'd0;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    BUSY        = 1'b0;
    A_GNT       = 1'b0;
    B_GNT       = 1'b0;
    MEM_WRITE   = 1'b0;
    MEM_ADDRESS = 10'd0;
    MEM_WDATA   = 10'd0;
    case (state_q)
      IDLE: begin
        if (A_REQ || B_REQ) begin
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        state_d     = RESP;
        BUSY        = 1'b1;
        A_GNT       = !owner_b_q;
        B_GNT       = owner_b_q;
        MEM_WRITE   = we_q && in_range;
        MEM_ADDRESS = addr_q;
        MEM_WDATA   = wdata_q;
      end
      RESP: begin
        state_d = IDLE;
        BUSY    = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The winner's command is latched on the grant edge. Later input changes
  // therefore cannot disturb the access that is in flight.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      owner_b_q <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= 10'd0;
      wdata_q   <= 10'd0;
    end else if (start) begin
      owner_b_q <= win_b;
      we_q      <= win_b ? B_WE    : A_WE;
      addr_q    <= win_b ? B_ADDR  : A_ADDR;
      wdata_q   <= win_b ? B_WDATA : A_WDATA;
    end
  end

  // Completion is registered on the RESP->IDLE edge. ERR and RDATA for a port
  // change only when that port completes, so they hold between its DONE pulses.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      a_done_q  <= 1'b0;
      a_err_q   <= 1'b0;
      a_rdata_q <= 10'd0;
      b_done_q  <= 1'b0;
      b_err_q   <= 1'b0;
      b_rdata_q <= 10'd0;
    end else begin
      a_done_q <= 1'b0;
      b_done_q <= 1'b0;
      if (state_q == RESP) begin
        if (owner_b_q) begin
          b_done_q  <= 1'b1;
          b_err_q   <= !in_range;
          b_rdata_q <= resp_data;
        end else begin
          a_done_q  <= 1'b1;
          a_err_q   <= !in_range;
          a_rdata_q <= resp_data;
        end
      end
    end
  end

  assign A_DONE  = a_done_q;
  assign A_ERR   = a_err_q;
  assign A_RDATA = a_rdata_q;
  assign B_DONE  = b_done_q;
  assign B_ERR   = b_err_q;
  assign B_RDATA = b_rdata_q;

endmodule
